// File: rtl/tm_mem_arbiter.sv
// Single-port memory arbiter between the TM core FSM and the host loader.
// Combinational round-robin grants, with a bounded core lock for read-modify-write sequences.
module tm_mem_arbiter #(
  parameter int dw       = 4,
  parameter int w        = 64,
  parameter int aw       = $clog2(w),
  parameter int LOCK_MAX = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [aw-1:0] h_addr,
  input  logic [dw-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [dw-1:0] h_rdata,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [aw-1:0] c_addr,
  input  logic [dw-1:0] c_wdata,
  input  logic          c_lock,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [dw-1:0] c_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [aw-1:0] mem_addr,
  output logic [dw-1:0] mem_wdata,
  input  logic [dw-1:0] mem_rdata,
  output logic          locked,
  output logic          lock_timeout
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  typedef enum logic { UNLOCKED = 1'b0, LOCKED = 1'b1 } state_t;
  typedef enum logic { PTR_CORE = 1'b0, PTR_HOST = 1'b1 } ptr_t;

  state_t        state;
  ptr_t          rr_ptr;
  logic [CW-1:0] lock_cnt;
  logic          timeout_hit;
  logic          h_win;
  logic          c_win;
  logic          h_rvld_p1;
  logic          c_rvld_p1;

  // p0: arbitration and memory issue in the grant cycle
  always_comb begin
    timeout_hit = (state == LOCKED) && (lock_cnt == CNT_MAX) && h_req;
    h_win       = 1'b0;
    c_win       = 1'b0;
    if (state == LOCKED) begin
      if (timeout_hit) h_win = 1'b1;
      else             c_win = c_req;
    end else if (h_req && c_req) begin
      c_win = (rr_ptr == PTR_CORE);
      h_win = (rr_ptr == PTR_HOST);
    end else begin
      c_win = c_req;
      h_win = h_req;
    end
  end

  assign h_gnt = h_win & ~reset;
  assign c_gnt = c_win & ~reset;

  assign mem_re    = (h_gnt & ~h_we) | (c_gnt & ~c_we);
  assign mem_we    = (h_gnt &  h_we) | (c_gnt &  c_we);
  assign mem_addr  = h_gnt ? h_addr  : (c_gnt ? c_addr  : '0);
  assign mem_wdata = h_gnt ? h_wdata : (c_gnt ? c_wdata : '0);

  assign locked = (state == LOCKED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= UNLOCKED;
      rr_ptr       <= PTR_CORE;
      lock_cnt     <= '0;
      lock_timeout <= 1'b0;
      h_rvld_p1    <= 1'b0;
      c_rvld_p1    <= 1'b0;
    end else begin
      h_rvld_p1    <= h_gnt & ~h_we;
      c_rvld_p1    <= c_gnt & ~c_we;
      lock_timeout <= timeout_hit;
      if (state == UNLOCKED) begin
        if (c_gnt) begin
          rr_ptr <= PTR_HOST;
          if (c_lock) begin
            state    <= LOCKED;
            lock_cnt <= CW'(1);
          end
        end else if (h_gnt) begin
          rr_ptr <= PTR_CORE;
        end
      end else begin
        // Forced release outranks everything else the core asks for.
        if (timeout_hit) begin
          state    <= UNLOCKED;
          lock_cnt <= '0;
          rr_ptr   <= PTR_CORE;
        end else if (c_gnt && !c_lock) begin
          state    <= UNLOCKED;
          lock_cnt <= '0;
          rr_ptr   <= PTR_HOST;
        end else if (!c_req && !c_lock) begin
          state    <= UNLOCKED;
          lock_cnt <= '0;
        end else if (lock_cnt != CNT_MAX) begin
          lock_cnt <= lock_cnt + CW'(1);
        end
      end
    end
  end

  // p1: read data returns one cycle after the read grant
  assign h_rvalid = h_rvld_p1;
  assign c_rvalid = c_rvld_p1;
  assign h_rdata  = h_rvld_p1 ? mem_rdata : '0;
  assign c_rdata  = c_rvld_p1 ? mem_rdata : '0;

endmodule
